control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 1, meaning: 1 = an illegal opcode enters HALT; 0 = it is retired as a NOP.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port instruction, input, 32 bits: the current instruction word from the datapath.
REQ-005 Port zero, input, 1 bit: the ALU zero flag from the datapath.
REQ-006 Ports branch, is_lui, is_jal, is_jalr, mem2reg, memwrite, alusrc, regwrite: outputs, 1 bit each, datapath control lines.
REQ-007 Port aluctl, output, 4 bits: ALU operation code.
REQ-008 Port pc_we, output, 1 bit: PC update enable into the datapath.
REQ-009 Port ir_we, output, 1 bit: instruction latch enable.
REQ-010 Port state, output, 3 bits: current FSM state.
REQ-011 Port illegal, output, 1 bit: sticky undecodable-opcode flag.
REQ-012 Port retired, output, 32 bits: count of retired instructions.

Function
REQ-013 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and HALT=5.
REQ-014 Transitions SHALL be:
- FETCH -> DECODE, always.
- DECODE -> EXEC if the opcode is legal; otherwise HALT (or FETCH as a NOP when HALT_ON_ILLEGAL=0).
- EXEC -> MEM for load/store, FETCH for beq, WB otherwise.
- MEM -> WB for load, FETCH for store.
- WB -> FETCH.
- HALT -> HALT, until reset.
REQ-015 Legal opcodes and their decode SHALL be:
- 0110011 R-type: add (f3=000, f7=0000000) -> aluctl 0010; sub (f3=000, f7=0100000) -> 0110; and (f3=111) -> 0000; or (f3=110) -> 0001; slt (f3=010) -> 0111.
- 0010011 addi (f3=000): aluctl 0010, alusrc=1.
- 0000011 lw: aluctl 0010, alusrc=1, mem2reg=1.
- 0100011 sw: aluctl 0010, alusrc=1.
- 1100011 beq: aluctl 0110, alusrc=0.
- 1101111 jal: is_jal=1.
- 1100111 jalr: is_jalr=1, alusrc=1.
- 0110111 lui: is_lui=1.
REQ-016 Any other opcode or funct combination SHALL be illegal.
REQ-017 Decode fields (aluctl, alusrc, mem2reg, is_lui, is_jal, is_jalr) SHALL be registered on the DECODE->EXEC edge and held constant until the next FETCH.
REQ-018 Decode fields SHALL read 0 during FETCH, DECODE and HALT.
REQ-019 ir_we SHALL be 1 only in FETCH.
REQ-020 branch SHALL be 1 only in EXEC for beq.
REQ-021 memwrite SHALL be 1 only in MEM for sw.
REQ-022 regwrite SHALL be 1 only in WB, and only for R-type, addi, lw, jal, jalr and lui.
REQ-023 pc_we SHALL be 1 for exactly one cycle per instruction: in EXEC for beq, in MEM for sw, in WB otherwise, and in DECODE for an illegal opcode treated as a NOP.
REQ-024 Latency SHALL be 3 cycles for beq, 4 cycles for sw, R-type, addi, jal, jalr and lui, and 5 cycles for lw.
REQ-025 The sequencer SHALL NOT evaluate zero; the datapath combines branch with zero.
REQ-026 retired SHALL increment by 1 on every clock edge where pc_we=1, wrapping from 0xFFFFFFFF to 0.
REQ-027 illegal SHALL set on entry to HALT and stay set until reset.
REQ-028 illegal SHALL stay 0 when HALT_ON_ILLEGAL=0.
REQ-029 In HALT, all strobes (ir_we, pc_we, regwrite, memwrite, branch) SHALL be 0.
REQ-030 Changes of instruction outside DECODE SHALL have no effect on the outputs.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force: state=FETCH, decode registers=0, retired=0, illegal=0.
REQ-032 While rst_n=0, all strobes except ir_we SHALL be 0.
REQ-033 Reset asserted in any state, including mid-lw in MEM, SHALL abort the instruction with no regwrite or memwrite pulse.
REQ-034 After rst_n rises, the first rising clk edge SHALL move state from FETCH to DECODE.

Verification
REQ-035 Scenario add: instruction=0x002081B3 (add x3,x1,x2) -> states 0,1,2,4; aluctl=0010 and alusrc=0 from EXEC; regwrite=1 and pc_we=1 in WB only; retired=1.
REQ-036 Scenario lw: instruction=0x0000A183 -> states 0,1,2,3,4; mem2reg=1 from EXEC through WB; memwrite=0 throughout; regwrite=1 in WB.
REQ-037 Scenario sw and beq: instruction=0x0030A023 (sw) -> memwrite=1 and pc_we=1 in MEM, no WB state; instruction=0x00208463 (beq) -> branch=1, pc_we=1 and aluctl=0110 in EXEC, back in FETCH next cycle.
REQ-038 Scenario illegal: instruction=0xFFFFFFFF with HALT_ON_ILLEGAL=1 -> state=5, illegal=1, strobes 0 for 10 or more cycles; with HALT_ON_ILLEGAL=0 -> pc_we=1 in DECODE, illegal=0, retired increments.
REQ-039 Scenario reset mid-operation: rst_n pulsed low during MEM of an lw -> state=0 and retired=0 asynchronously, no regwrite pulse, normal execution resumes afterwards.
REQ-040 Scenario counter wrap: retired forced to 0xFFFFFFFF, one jal (0x008000EF) retired -> retired=0, regwrite=1 and is_jal=1 in WB.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FSM that decodes a small RV32I subset into datapath
// control lines, with a retired-instruction counter and a sticky illegal-opcode flag.
module control_sequencer #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        zero,
    output logic        branch,
    output logic        is_lui,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        mem2reg,
    output logic        memwrite,
    output logic        alusrc,
    output logic        regwrite,
    output logic [3:0]  aluctl,
    output logic        pc_we,
    output logic        ir_we,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t cur, nxt;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] d_aluctl;
    logic d_legal, d_alusrc, d_mem2reg, d_lui, d_jal, d_jalr, d_load, d_store, d_beq;
    logic r_load, r_store, r_beq, r_wr;
    logic unused_ok;

    assign op = instruction[6:0];
    assign f3 = instruction[14:12];
    assign f7 = instruction[31:25];
    // The branch outcome is resolved in the datapath, so zero and operand fields are ignored here.
    assign unused_ok = &{1'b0, zero, instruction[24:15], instruction[11:7]};

    always_comb begin
        d_legal   = 1'b0;
        d_aluctl  = 4'b0000;
        d_alusrc  = 1'b0;
        d_mem2reg = 1'b0;
        d_lui     = 1'b0;
        d_jal     = 1'b0;
        d_jalr    = 1'b0;
        d_load    = 1'b0;
        d_store   = 1'b0;
        d_beq     = 1'b0;
        case (op)
            7'b0110011: begin
                d_legal  = (f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010))
                         || (f7 == 7'b0100000 && f3 == 3'b000);
                d_aluctl = f7[5] ? 4'b0110 : f3 == 3'b111 ? 4'b0000 : f3 == 3'b110 ? 4'b0001 :
                           f3 == 3'b010 ? 4'b0111 : 4'b0010;
            end
            7'b0010011: begin
                d_legal  = f3 == 3'b000;
                d_aluctl = 4'b0010;
                d_alusrc = 1'b1;
            end
            7'b0000011: begin
                d_legal   = 1'b1;
                d_aluctl  = 4'b0010;
                d_alusrc  = 1'b1;
                d_mem2reg = 1'b1;
                d_load    = 1'b1;
            end
            7'b0100011: begin
                d_legal  = 1'b1;
                d_aluctl = 4'b0010;
                d_alusrc = 1'b1;
                d_store  = 1'b1;
            end
            7'b1100011: begin
                d_legal  = 1'b1;
                d_aluctl = 4'b0110;
                d_beq    = 1'b1;
            end
            7'b1101111: begin
                d_legal = 1'b1;
                d_jal   = 1'b1;
            end
            7'b1100111: begin
                d_legal  = 1'b1;
                d_jalr   = 1'b1;
                d_alusrc = 1'b1;
            end
            7'b0110111: begin
                d_legal = 1'b1;
                d_lui   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:   nxt = DECODE;
            DECODE:  nxt = d_legal ? EXEC : HALT_ON_ILLEGAL ? HALT : FETCH;
            EXEC:    nxt = (r_load || r_store) ? MEM : r_beq ? FETCH : WB;
            MEM:     nxt = r_load ? WB : FETCH;
            WB:      nxt = FETCH;
            default: nxt = HALT;
        endcase
    end

    assign state    = cur;
    assign ir_we    = cur == FETCH;
    assign branch   = cur == EXEC && r_beq;
    assign memwrite = cur == MEM && r_store;
    assign regwrite = cur == WB && r_wr;
    assign pc_we    = branch || memwrite || cur == WB || (cur == DECODE && !d_legal && !HALT_ON_ILLEGAL);

    // Decode fields are captured once per instruction and cleared on the way back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= FETCH;
            illegal <= 1'b0;
            retired <= 32'd0;
            {aluctl, alusrc, mem2reg, is_lui, is_jal, is_jalr, r_load, r_store, r_beq, r_wr} <= '0;
        end else begin
            cur <= nxt;
            if (pc_we)
                retired <= retired + 32'd1;
            if (nxt == HALT)
                illegal <= 1'b1;
            if (cur == DECODE && d_legal)
                {aluctl, alusrc, mem2reg, is_lui, is_jal, is_jalr, r_load, r_store, r_beq, r_wr} <=
                    {d_aluctl, d_alusrc, d_mem2reg, d_lui, d_jal, d_jalr, d_load, d_store, d_beq, !(d_store || d_beq)};
            else if (nxt == FETCH)
                {aluctl, alusrc, mem2reg, is_lui, is_jal, is_jalr, r_load, r_store, r_beq, r_wr} <= '0;
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scoreboard bench; expected per-cycle outputs are queued
// when an instruction is driven and popped at each falling clock edge.
module tb_control_sequencer;
    typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_JAL, K_JALR, K_LUI, K_ILL, K_NOP} kind_t;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir_we, pc_we, regwrite, memwrite, branch;
        logic [3:0]  aluctl;
        logic        alusrc, mem2reg, lui, jal, jalr, ill;
        logic [31:0] ret;
    } rec_t;

    logic clk, rst_n, rst0_n, zero;
    logic [31:0] instruction, instr0;
    logic branch, is_lui, is_jal, is_jalr, mem2reg, memwrite, alusrc, regwrite, pc_we, ir_we, illegal;
    logic [3:0] aluctl;
    logic [2:0] state;
    logic [31:0] retired;
    logic branch0, is_lui0, is_jal0, is_jalr0, mem2reg0, memwrite0, alusrc0, regwrite0, pc_we0, ir_we0, illegal0;
    logic [3:0] aluctl0;
    logic [2:0] state0;
    logic [31:0] retired0;

    rec_t q[$];
    logic [31:0] exp_ret;
    int n_chk = 0, n_pass = 0, n_fail = 0;

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero),
        .branch(branch), .is_lui(is_lui), .is_jal(is_jal), .is_jalr(is_jalr),
        .mem2reg(mem2reg), .memwrite(memwrite), .alusrc(alusrc), .regwrite(regwrite),
        .aluctl(aluctl), .pc_we(pc_we), .ir_we(ir_we), .state(state),
        .illegal(illegal), .retired(retired)
    );

    control_sequencer #(.HALT_ON_ILLEGAL(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .instruction(instr0), .zero(zero),
        .branch(branch0), .is_lui(is_lui0), .is_jal(is_jal0), .is_jalr(is_jalr0),
        .mem2reg(mem2reg0), .memwrite(memwrite0), .alusrc(alusrc0), .regwrite(regwrite0),
        .aluctl(aluctl0), .pc_we(pc_we0), .ir_we(ir_we0), .state(state0),
        .illegal(illegal0), .retired(retired0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t mk(logic [2:0] st, kind_t k, logic [3:0] alu, logic [31:0] ret);
        rec_t r;
        r = '0;
        r.st    = st;
        r.ret   = ret;
        r.ir_we = st == 3'd0;
        if (st >= 3'd2 && st <= 3'd4) begin
            r.aluctl  = alu;
            r.alusrc  = k == K_I || k == K_LW || k == K_SW || k == K_JALR;
            r.mem2reg = k == K_LW;
            r.lui     = k == K_LUI;
            r.jal     = k == K_JAL;
            r.jalr    = k == K_JALR;
        end
        r.branch   = st == 3'd2 && k == K_BEQ;
        r.memwrite = st == 3'd3 && k == K_SW;
        r.regwrite = st == 3'd4;
        r.pc_we    = r.branch || r.memwrite || st == 3'd4 || (st == 3'd1 && k == K_NOP);
        r.ill      = st == 3'd5;
        return r;
    endfunction

    function automatic rec_t obs(bit which);
        return which ? {state0, ir_we0, pc_we0, regwrite0, memwrite0, branch0, aluctl0, alusrc0, mem2reg0,
                        is_lui0, is_jal0, is_jalr0, illegal0, retired0}
                     : {state, ir_we, pc_we, regwrite, memwrite, branch, aluctl, alusrc, mem2reg,
                        is_lui, is_jal, is_jalr, illegal, retired};
    endfunction

    task automatic check(string tag, bit which);
        rec_t e, o;
        e = q.pop_front();
        o = obs(which);
        n_chk++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic push_state(logic [2:0] st, kind_t k, logic [3:0] alu);
        rec_t r;
        r = mk(st, k, alu, exp_ret);
        q.push_back(r);
        if (r.pc_we)
            exp_ret = exp_ret + 32'd1;
    endtask

    // Drives one instruction from FETCH and checks every cycle until the FSM is back in FETCH.
    task automatic run(string tag, bit which, logic [31:0] ins, kind_t k, logic [3:0] alu);
        int n;
        if (which) instr0 = ins; else instruction = ins;
        push_state(3'd0, k, alu);
        push_state(3'd1, k, alu);
        if (k == K_ILL)
            for (int i = 0; i < 10; i++) push_state(3'd5, k, alu);
        else if (k != K_NOP) begin
            push_state(3'd2, k, alu);
            if (k == K_LW || k == K_SW) push_state(3'd3, k, alu);
            if (k != K_SW && k != K_BEQ) push_state(3'd4, k, alu);
        end
        n = q.size();
        for (int i = 0; i < n; i++) begin
            check(tag, which);
            if (i == 2) begin
                if (which) instr0 = $urandom; else instruction = $urandom;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        rst0_n = 1'b1;
        zero = 1'b0;
        instruction = 32'h0;
        instr0 = 32'hFFFFFFFF;
        exp_ret = 32'd0;
        #1 rst_n = 1'b0;
        rst0_n = 1'b0;
        #2 push_state(3'd0, K_R, 4'b0000);
        check("reset_async", 0);
        push_state(3'd0, K_R, 4'b0000);
        check("reset_async0", 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run("add",  0, 32'h002081B3, K_R,    4'b0010);
        run("lw",   0, 32'h0000A183, K_LW,   4'b0010);
        run("sw",   0, 32'h0030A023, K_SW,   4'b0010);
        run("beq",  0, 32'h00208463, K_BEQ,  4'b0110);
        run("sub",  0, 32'h402081B3, K_R,    4'b0110);
        run("and",  0, 32'h0020F1B3, K_R,    4'b0000);
        run("or",   0, 32'h0020E1B3, K_R,    4'b0001);
        run("slt",  0, 32'h0020A1B3, K_R,    4'b0111);
        run("addi", 0, 32'h00508193, K_I,    4'b0010);
        run("jalr", 0, 32'h000100E7, K_JALR, 4'b0000);
        run("lui",  0, 32'h123452B7, K_LUI,  4'b0000);

        instruction = 32'h0000A183;
        for (int s = 0; s < 4; s++) push_state(3'(s), K_LW, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            check("lw_pre_rst", 0);
            if (i < 3) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1 exp_ret = 32'd0;
        push_state(3'd0, K_R, 4'b0000);
        check("rst_mid_mem", 0);
        @(posedge clk);
        #1 push_state(3'd0, K_R, 4'b0000);
        check("rst_hold", 0);
        @(negedge clk);
        rst_n = 1'b1;
        run("add_after_rst", 0, 32'h002081B3, K_R, 4'b0010);

        force dut.retired = 32'hFFFFFFFF;
        #1 release dut.retired;
        exp_ret = 32'hFFFFFFFF;
        run("jal_wrap", 0, 32'h008000EF, K_JAL, 4'b0000);
        run("halt", 0, 32'hFFFFFFFF, K_ILL, 4'b0000);

        rst0_n = 1'b1;
        exp_ret = 32'd0;
        run("nop",       1, 32'hFFFFFFFF, K_NOP, 4'b0000);
        run("nop2",      1, 32'hFFFFFFFF, K_NOP, 4'b0000);
        run("nop_funct", 1, 32'h002091B3, K_NOP, 4'b0000);
        run("add_nohalt", 1, 32'h002081B3, K_R, 4'b0010);
        push_state(3'd0, K_R, 4'b0000);
        check("final0", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
